// File: rtl/fifo_param.sv
// fifo_param: single-clock parameterised FIFO with occupancy count,
// threshold flags and sticky overflow/underflow error flags.
//
// Parameters:
//   DATA_WIDTH  word width
//   ADDR_WIDTH  log2 of depth (DEPTH = 2**ADDR_WIDTH, 1..10)
//   AF_LEVEL    almost_full_o when cnt_o >= AF_LEVEL (default DEPTH-1)
//   AE_LEVEL    almost_empty_o when cnt_o <= AE_LEVEL (default 1)
//
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync flush)
//   wen_i/data_i       write request and data
//   ren_i/data_o       read request (pop) and read data
//   full_o, empty_o, almost_full_o, almost_empty_o, cnt_o
//   overflow_o, underflow_o  sticky until rst_i or clear_i
//
// Build option:
//   FIFO_PARAM_FWFT_EN  first-word-fall-through: data_o shows the head
//   entry combinationally (0 when empty). Undefined: data_o is a register
//   loaded with the popped word one cycle after an accepted read.
module fifo_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ren_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   cnt_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_THR   = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_THR   = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  rd_acc;
  logic                  wr_acc;

  assign cnt_o          = cnt_q;
  assign full_o         = (cnt_q == CNT_FULL);
  assign empty_o        = (cnt_q == '0);
  assign almost_full_o  = (cnt_q >= AF_THR);
  assign almost_empty_o = (cnt_q <= AE_THR);
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

  // A write into a full FIFO still goes through when a read frees a slot
  // in the same cycle; the read takes the pre-write head.
  assign rd_acc = ren_i & ~empty_o;
  assign wr_acc = wen_i & (~full_o | rd_acc);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      cnt_q <= cnt_q + 1'b1;
      else if (rd_acc && !wr_acc) cnt_q <= cnt_q - 1'b1;
      if (wen_i && !wr_acc) ovf_q <= 1'b1;
      if (ren_i && empty_o) unf_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset; reset/clear only move the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !clear_i) mem[wr_ptr] <= data_i;
  end

`ifdef FIFO_PARAM_FWFT_EN
  assign data_o = empty_o ? '0 : mem[rd_ptr];
`else
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   data_q <= '0;
    else if (!clear_i && rd_acc) data_q <= mem[rd_ptr];
  end

  assign data_o = data_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Testbench for fifo_param (DEPTH 8, AF_LEVEL 6, AE_LEVEL 3): directed
// scenarios plus randomized traffic, every cycle compared against a
// queue-based reference model.
module tb_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          wen;
  logic          ren;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          full, empty, afull, aempty, ovf, unf;
  logic [AW:0]   cnt;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic          m_ovf;
  logic          m_unf;

  always #5 clk = ~clk;

  fifo_param #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .wen_i         (wen),
    .data_i        (din),
    .ren_i         (ren),
    .data_o        (dout),
    .full_o        (full),
    .empty_o       (empty),
    .almost_full_o (afull),
    .almost_empty_o(aempty),
    .cnt_o         (cnt),
    .overflow_o    (ovf),
    .underflow_o   (unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_dout();
`ifdef FIFO_PARAM_FWFT_EN
    return (q.size() > 0) ? q[0] : '0;
`else
    return m_data;
`endif
  endfunction

  task automatic check_all(input string ctx);
    int n;
    n = q.size();
    check({ctx, ".cnt"},    32'(cnt),    32'(n));
    check({ctx, ".full"},   32'(full),   32'(n == DEPTH));
    check({ctx, ".empty"},  32'(empty),  32'(n == 0));
    check({ctx, ".afull"},  32'(afull),  32'(n >= AF));
    check({ctx, ".aempty"}, 32'(aempty), 32'(n <= AE));
    check({ctx, ".ovf"},    32'(ovf),    32'(m_ovf));
    check({ctx, ".unf"},    32'(unf),    32'(m_unf));
    check({ctx, ".data"},   32'(dout),   32'(exp_dout()));
  endtask

  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock cycle: drive at negedge, advance model at posedge, check after.
  task automatic step(input logic w, input logic r, input logic c,
                      input logic [DW-1:0] d, input string ctx);
    bit rd_ok, wr_ok;
    @(negedge clk);
    wen = w; ren = r; clear = c; din = d;
    @(posedge clk);
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      if (r && !rd_ok) m_unf = 1'b1;
      if (w && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) m_data = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    #1;
    check_all(ctx);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; wen = 1'b0; ren = 1'b0; din = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill with 0x11..0x18 then drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h11 + i), "fill");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0, "drain");

    // Write into full FIFO is rejected and flagged
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h21 + i), "fill2");
    step(1'b1, 1'b0, 1'b0, 8'hAA, "ovf");
    // Simultaneous write+read when full: count holds, oldest popped
    step(1'b1, 1'b1, 1'b0, 8'h55, "full_rw");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0, "drain2");
    step(1'b0, 1'b0, 1'b0, '0, "idle");

    // Simultaneous write+read when empty: read rejected, write lands
    step(1'b1, 1'b1, 1'b0, 8'h3C, "empty_rw");
    step(1'b0, 1'b1, 1'b0, '0, "rd3c");
    step(1'b1, 1'b1, 1'b1, 8'h77, "clear");
    step(1'b0, 1'b0, 1'b0, '0, "post_clr");

    // Interleaved traffic holding occupancy in 3..6 across pointer wrap
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom), "pre");
    for (int i = 0; i < 20; i++) begin
      logic w, r;
      if (q.size() <= 3)      begin w = 1'b1; r = 1'($urandom_range(0, 1)); end
      else if (q.size() >= 6) begin w = 1'($urandom_range(0, 1)); r = 1'b1; end
      else begin w = 1'($urandom); r = 1'($urandom); end
      step(w, r, 1'b0, DW'($urandom), "ilv");
    end

    // Asynchronous reset between edges with 5 words stored
    step(1'b1, 1'b1, 1'b1, '0, "clr2");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom), "pre_rst");
    @(negedge clk);
    wen = 1'b0; ren = 1'b0; clear = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0, "after_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 3), DW'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
